// File: rtl/fetch_decode_regs.sv
// Architectural register stage of the multi-cycle RISC-V core: PC, OldPC, IR, MDR,
// IR field slicing and illegal-opcode halt. Optional macro: FETCH_DECODE_PERF_COUNTERS_EN.
module fetch_decode_regs #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] result,
    input  logic        ir_write,
    input  logic        old_pc_write,
    input  logic        pc_write_result,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic [6:0]  opcode,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        illegal,
    output logic        halted,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state, next_state;
    logic   opcode_legal;
    logic   word_illegal;
    logic   capture_illegal;

    always_comb begin
        opcode_legal = 1'b0;
        case (mem_rdata[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111: opcode_legal = 1'b1;
            default: opcode_legal = 1'b0;
        endcase
        word_illegal    = !opcode_legal || (HALT_ON_ZERO && (mem_rdata == 32'h0));
        capture_illegal = (state == RUN) && ir_write && word_illegal;
    end

    always_comb begin
        next_state = state;
        if (capture_illegal) begin
            next_state = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Strobes only act in RUN; mdr tracks memory in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            old_pc  <= 32'h0;
            instr   <= 32'h0000_0013;
            mdr     <= 32'h0;
            illegal <= 1'b0;
        end else begin
            mdr <= mem_rdata;
            if (state == RUN) begin
                if (ir_write) begin
                    instr <= mem_rdata;
                end
                if (old_pc_write) begin
                    old_pc <= pc;
                end
                if (pc_write_result) begin
                    pc <= result;
                end
                if (capture_illegal) begin
                    illegal <= 1'b1;
                end
            end
        end
    end

    assign halted = (state == HALT);

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

`ifdef FETCH_DECODE_PERF_COUNTERS_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    // Both counters freeze once HALT is reached; wrap is natural 32-bit overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= 32'h0;
            instret_q <= 32'h0;
        end else if (state == RUN) begin
            cycle_q <= cycle_q + 32'd1;
            if (ir_write && !word_illegal) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`else
    assign cycle_count   = 32'h0;
    assign instret_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_decode_regs.sv
// Self-checking bench for fetch_decode_regs: directed steps push expected state into a
// scoreboard queue, which is popped and compared one clock later.
module tb_fetch_decode_regs;

    logic        clk;
    logic        reset;
    logic [31:0] mem_rdata;
    logic [31:0] result;
    logic        ir_write;
    logic        old_pc_write;
    logic        pc_write_result;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] instr;
    logic [31:0] mdr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
    logic        halted;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    fetch_decode_regs #(
        .RESET_PC    (32'h0000_0100),
        .HALT_ON_ZERO(1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_rdata      (mem_rdata),
        .result         (result),
        .ir_write       (ir_write),
        .old_pc_write   (old_pc_write),
        .pc_write_result(pc_write_result),
        .pc             (pc),
        .old_pc         (old_pc),
        .instr          (instr),
        .mdr            (mdr),
        .opcode         (opcode),
        .f3             (f3),
        .f7             (f7),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .illegal        (illegal),
        .halted         (halted),
        .cycle_count    (cycle_count),
        .instret_count  (instret_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] old_pc;
        logic [31:0] instr;
        logic [31:0] mdr;
        logic [31:0] cyc;
        logic [31:0] ret;
        logic        ill;
    } exp_t;

    exp_t        sb_q[$];
    string       tag_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        m_halted = 1'b0;
    logic [31:0] m_cyc = 32'h0;
    logic [31:0] m_ret = 32'h0;

    task automatic check32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Decode fields are compared against slices of the expected instruction word.
    task automatic checkOutput();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check32({t, ".pc"},      pc,                  e.pc);
        check32({t, ".old_pc"},  old_pc,              e.old_pc);
        check32({t, ".instr"},   instr,               e.instr);
        check32({t, ".mdr"},     mdr,                 e.mdr);
        check32({t, ".opcode"},  {25'h0, opcode},     {25'h0, e.instr[6:0]});
        check32({t, ".rd"},      {27'h0, rd},         {27'h0, e.instr[11:7]});
        check32({t, ".f3"},      {29'h0, f3},         {29'h0, e.instr[14:12]});
        check32({t, ".rs1"},     {27'h0, rs1},        {27'h0, e.instr[19:15]});
        check32({t, ".rs2"},     {27'h0, rs2},        {27'h0, e.instr[24:20]});
        check32({t, ".f7"},      {25'h0, f7},         {25'h0, e.instr[31:25]});
        check32({t, ".illegal"}, {31'h0, illegal},    {31'h0, e.ill});
        check32({t, ".halted"},  {31'h0, halted},     {31'h0, e.ill});
        check32({t, ".cycles"},  cycle_count,         e.cyc);
        check32({t, ".instret"}, instret_count,       e.ret);
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic irw,
                                 input logic opw, input logic pcw,
                                 input logic [31:0] mem, input logic [31:0] res,
                                 input logic [31:0] e_pc, input logic [31:0] e_old,
                                 input logic [31:0] e_instr, input logic e_ill);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        ir_write        = irw;
        old_pc_write    = opw;
        pc_write_result = pcw;
        mem_rdata       = mem;
        result          = res;
        if (rst) begin
            m_cyc    = 32'h0;
            m_ret    = 32'h0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            m_cyc = m_cyc + 32'd1;
            if (irw && !e_ill) m_ret = m_ret + 32'd1;
            m_halted = e_ill;
        end
        e.pc     = e_pc;
        e.old_pc = e_old;
        e.instr  = e_instr;
        e.mdr    = rst ? 32'h0 : mem;
        e.ill    = e_ill;
`ifdef FETCH_DECODE_PERF_COUNTERS_EN
        e.cyc    = m_cyc;
        e.ret    = m_ret;
`else
        e.cyc    = 32'h0;
        e.ret    = 32'h0;
`endif
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0]  ops [8];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        reset = 1'b1; ir_write = 1'b0; old_pc_write = 1'b0; pc_write_result = 1'b0;
        mem_rdata = 32'h0; result = 32'h0;

        //            tag         rst  ir  op  pcw  mem           result        pc            old_pc        instr         ill
        applyStimulus("reset",    1,   0,  0,  0,   32'h1111_1111, 32'h0,       32'h100,      32'h0,        32'h13,       0);
        applyStimulus("fetch",    0,   1,  1,  1,   32'h00A2_8293, 32'h104,     32'h104,      32'h100,      32'h00A2_8293, 0);
        applyStimulus("load",     0,   0,  0,  0,   32'hDEAD_BEEF, 32'h999,     32'h104,      32'h100,      32'h00A2_8293, 0);
        applyStimulus("oldpc",    0,   0,  1,  0,   32'h0,         32'h0,       32'h104,      32'h104,      32'h00A2_8293, 0);
        applyStimulus("ir_only",  0,   1,  0,  0,   32'h1234_52B7, 32'h777,     32'h104,      32'h104,      32'h1234_52B7, 0);
        applyStimulus("pc_only",  0,   0,  0,  1,   32'h0,         32'h108,     32'h108,      32'h104,      32'h1234_52B7, 0);
        applyStimulus("ir_pc",    0,   1,  0,  1,   32'h0062_A023, 32'h10C,     32'h10C,      32'h104,      32'h0062_A023, 0);
        applyStimulus("illegal",  0,   1,  0,  1,   32'hFFFF_FFFF, 32'h110,     32'h110,      32'h104,      32'hFFFF_FFFF, 1);
        applyStimulus("halt1",    0,   1,  1,  1,   32'h0000_0013, 32'h200,     32'h110,      32'h104,      32'hFFFF_FFFF, 1);
        applyStimulus("halt2",    0,   1,  1,  1,   32'h0000_ABCD, 32'h200,     32'h110,      32'h104,      32'hFFFF_FFFF, 1);
        applyStimulus("rst_halt", 1,   0,  0,  0,   32'h5555_5555, 32'h0,       32'h100,      32'h0,        32'h13,       0);
        applyStimulus("zero_w",   0,   1,  1,  0,   32'h0,         32'h300,     32'h100,      32'h100,      32'h0,        1);
        applyStimulus("rst2",     1,   1,  1,  1,   32'hFFFF_FFFF, 32'h400,     32'h100,      32'h0,        32'h13,       0);

        for (int i = 0; i < 8; i++) begin
            w = {20'h00000, 5'd1, ops[i]};
            applyStimulus($sformatf("legal%0d", i), 0, 1, 0, 0, w, 32'h0, 32'h100, 32'h0, w, 0);
        end
        applyStimulus("ecall",    0,   1,  0,  0,   32'h0000_0073, 32'h0,       32'h100,      32'h0,        32'h0000_0073, 1);
        applyStimulus("rst3",     1,   1,  1,  1,   32'h0000_0000, 32'h500,     32'h100,      32'h0,        32'h13,       0);
        applyStimulus("post_rst", 0,   1,  1,  1,   32'h0000_006F, 32'h180,     32'h180,      32'h100,      32'h0000_006F, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode_regs.md
Name: fetch_decode_regs

Overview:
Architectural register stage of the multi-cycle RISC-V core. Holds PC, OldPC, IR and MDR, and slices IR into the opcode, f3 and f7 fields consumed by the controller.
Captures memory read data under the controller's ir_write, old_pc_write and pc_write_result strobes. Also screens each fetched word for a legal opcode, and halts the core on an illegal one.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
HALT_ON_ZERO, 1, when 1 the all-zero instruction word is treated as illegal and halts the core.

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
mem_rdata  in  32  unified memory read data
result  in  32  result-mux output, next-PC value
ir_write  in  1  load IR from mem_rdata
old_pc_write  in  1  load OldPC from PC
pc_write_result  in  1  load PC from result
pc  out  32  program counter, drives memory address when adr_src=0
old_pc  out  32  PC of the instruction in IR
instr  out  32  instruction register
mdr  out  32  memory data register
opcode  out  7  instr[6:0]
f3  out  3  instr[14:12]
f7  out  7  instr[31:25]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
rd  out  5  instr[11:7]
illegal  out  1  registered; last captured instruction was illegal
halted  out  1  core halted (state HALT)
cycle_count  out  32  see Optional Feature
instret_count  out  32  see Optional Feature

Behaviour:
- Reset, synchronous, dominates all strobes:
  - pc=RESET_PC, old_pc=0, instr=32'h0000_0013 (NOP), mdr=0.
  - illegal=0, halted=0, state=RUN, both counters=0.
- Decode outputs are pure slices of instr. They change only when instr changes.
- mdr <= mem_rdata every cycle, in all states (non-architectural, one-cycle latency).
- All registers sample pre-edge values. When old_pc_write and pc_write_result are both high in one cycle:
  - old_pc gets the old pc.
  - pc gets result.
- Any combination of ir_write, old_pc_write and pc_write_result in one cycle is legal. Each target updates independently.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111.
  - Any other opcode is illegal.
  - mem_rdata==0 is also illegal when HALT_ON_ZERO=1.
- FSM states are RUN and HALT.
- RUN:
  - ir_write=1 loads instr<=mem_rdata.
  - If that word is illegal, set illegal<=1 and halted<=1 on the same edge, then go to HALT.
  - A pc_write_result or old_pc_write in that same cycle is still honoured.
- HALT:
  - pc, old_pc and instr are frozen. All three strobes are ignored.
  - illegal and halted stay 1 (sticky).
  - mdr keeps updating.
  - The only exit is reset, which returns to RUN with reset values.
- Reset mid-instruction discards the in-flight instruction. No partial state survives.
- PC arithmetic is done upstream. result is stored unmodified, with no alignment check.

Optional Feature:
- Macro: FETCH_DECODE_PERF_COUNTERS_EN.
- When defined:
  - cycle_count increments every non-reset cycle while in RUN.
  - instret_count increments on each RUN-state ir_write that captures a legal word.
  - Both wrap 32'hFFFF_FFFF -> 0 and freeze in HALT.
- When undefined: both ports are still present and tied to 0, with no counter flops.

Test Plan:
- Reset with RESET_PC=32'h100 -> pc=0x100, instr=0x13, opcode=7'h13, old_pc=0, illegal=0, halted=0.
- Fetch: mem_rdata=0x00A28293 with ir_write=1, old_pc_write=1, pc_write_result=1, result=0x104 -> next cycle instr=0x00A28293, opcode=0x13, rd=5, rs1=5, f3=0, old_pc=0x100, pc=0x104.
- Load capture: mem_rdata=0xDEADBEEF with no strobes -> mdr=0xDEADBEEF one cycle later; pc, instr and old_pc unchanged.
- Illegal word 0xFFFFFFFF with ir_write=1, pc_write_result=1, result=0x108 -> pc=0x108, instr=0xFFFFFFFF, illegal=1, halted=1. Later strobes with result=0x200 -> pc stays 0x108.
- Reset asserted while halted -> next cycle halted=0, illegal=0, pc=RESET_PC, instr=0x13.
- FETCH_DECODE_PERF_COUNTERS_EN defined, 3 legal fetches over 10 cycles then an illegal fetch -> instret_count=3 and cycle_count frozen at its halt-entry value. Undefined -> both stay 0.
